// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   state_t   : drain FSM states (RUN, DRAIN)
//   STG_*     : fixed stage indices of IF, ID and EX
//   CNT_W     : width of the outstanding-transaction counters
package pipe_pkg;
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int CNT_W  = 3;
endpackage

// File: rtl/outst_cnt.sv
// Credit counter for one in-order request/response bus.
//   clk, rst  : clock, synchronous active-high reset
//   req       : request valid
//   addr_ok   : request accepted this cycle
//   data_ok   : one response returned this cycle
//   cnt       : outstanding transactions
//   req_ok    : a credit is free (forced high while rst)
module outst_cnt
  import pipe_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             addr_ok,
  input  logic             data_ok,
  output logic [CNT_W-1:0] cnt,
  output logic             req_ok
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic acc;

  // A net increment at MAX or a net decrement at 0 is a bus protocol
  // violation; the count holds instead of wrapping.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cur,
                                                input logic inc, input logic dec);
    if (inc && !dec && cur >= MAX_C) return cur;
    if (!inc && dec && cur == '0) return cur;
    return cur + CNT_W'(inc) - CNT_W'(dec);
  endfunction

  assign acc    = req && addr_ok;
  assign req_ok = rst || (cnt < MAX_C);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= next_cnt(cnt, acc, data_ok);
  end

  assert property (@(posedge clk) disable iff (rst) !(acc && !data_ok && cnt >= MAX_C));
  assert property (@(posedge clk) disable iff (rst) !(!acc && data_ok && cnt == '0));
endmodule

// File: rtl/pipe_ctrl_n.sv
// Stall/flush controller for an NSTAGE in-order pipeline.
//   clk, rst                    : clock, synchronous active-high reset
//   inst_req/addr_ok/data_ok    : IF bus handshake
//   data_req/addr_ok/data_ok    : EX bus handshake
//   id_rs_ren/id_rs/id_rt_ren/id_rt : ID source operands
//   stg_wen/stg_wreg/stg_late   : per-stage destination and late-result flags
//   ext_stall                   : external per-stage stall causes
//   exc, eret                   : redirect taken at COMMIT
//   stall, flush                : per-stage register hold / clear-to-bubble
//   inst_cancel                 : drop the current inst_data_ok as stale
//   inst_req_ok, data_req_ok    : bus credits available
//   inst_outst, data_outst      : outstanding transaction counts
module pipe_ctrl_n
  import pipe_pkg::*;
#(
  parameter int NSTAGE    = 5,
  parameter int COMMIT    = 3,
  parameter int MAX_OUTST = 2,
  parameter int RW        = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_req,
  input  logic                 inst_addr_ok,
  input  logic                 inst_data_ok,
  input  logic                 data_req,
  input  logic                 data_addr_ok,
  input  logic                 data_data_ok,
  input  logic                 id_rs_ren,
  input  logic [RW-1:0]        id_rs,
  input  logic                 id_rt_ren,
  input  logic [RW-1:0]        id_rt,
  input  logic [NSTAGE-1:0]    stg_wen,
  input  logic [NSTAGE*RW-1:0] stg_wreg,
  input  logic [NSTAGE-1:0]    stg_late,
  input  logic [NSTAGE-1:0]    ext_stall,
  input  logic                 exc,
  input  logic                 eret,
  output logic [NSTAGE-1:0]    stall,
  output logic [NSTAGE-1:0]    flush,
  output logic                 inst_cancel,
  output logic                 inst_req_ok,
  output logic                 data_req_ok,
  output logic [2:0]           inst_outst,
  output logic [2:0]           data_outst
);
  // Only EX and later stages can hold a late producer.
  localparam logic [NSTAGE-1:0] HAZ_MASK = {{(NSTAGE-2){1'b1}}, 2'b00};

  state_t              state;
  logic [3:0]          cancel_cnt;
  logic [3:0]          drain_ld;
  logic [NSTAGE-1:0]   haz;
  logic [NSTAGE-1:0]   cause;
  logic [NSTAGE-1:0]   base_stall;
  logic [NSTAGE-1:0]   base_flush;
  logic                id_haz;
  logic                take;
  logic                inst_acc;

  // Returns still owed to the pipeline when a redirect is taken; a return
  // arriving in the same cycle retires one of them.
  function automatic logic [3:0] drain_load(input logic [2:0] outst,
                                            input logic acc, input logic ret);
    logic [3:0] sum;
    sum = {1'b0, outst} + {3'b000, acc};
    if (ret && sum != 4'd0) sum = sum - 4'd1;
    return sum;
  endfunction

  outst_cnt #(.MAX(MAX_OUTST)) u_inst_cnt (
    .clk(clk), .rst(rst), .req(inst_req), .addr_ok(inst_addr_ok),
    .data_ok(inst_data_ok), .cnt(inst_outst), .req_ok(inst_req_ok)
  );

  outst_cnt #(.MAX(MAX_OUTST)) u_data_cnt (
    .clk(clk), .rst(rst), .req(data_req), .addr_ok(data_addr_ok),
    .data_ok(data_data_ok), .cnt(data_outst), .req_ok(data_req_ok)
  );

  for (genvar s = 0; s < NSTAGE; s++) begin : g_haz
    logic [RW-1:0] wreg;
    assign wreg   = stg_wreg[s*RW +: RW];
    assign haz[s] = stg_wen[s] && stg_late[s] && (wreg != '0) &&
                    ((id_rs_ren && wreg == id_rs) || (id_rt_ren && wreg == id_rt));
  end

  assign id_haz   = |(haz & HAZ_MASK);
  assign take     = exc || eret;
  assign inst_acc = inst_req && inst_addr_ok;
  assign drain_ld = drain_load(inst_outst, inst_acc, inst_data_ok);

  always_comb begin
    cause         = ext_stall;
    cause[STG_IF] = ext_stall[STG_IF] | (inst_req && !inst_addr_ok) | !inst_req_ok;
    cause[STG_ID] = ext_stall[STG_ID] | id_haz;
    cause[STG_EX] = ext_stall[STG_EX] | (data_req && !data_addr_ok) | !data_req_ok;
  end

  // A stalled stage back-pressures every younger stage; a stage that stalls
  // while its successor moves on leaves a bubble behind.
  always_comb begin
    base_stall             = '0;
    base_stall[NSTAGE-1]   = cause[NSTAGE-1];
    for (int s = NSTAGE - 2; s >= 0; s--)
      base_stall[s] = cause[s] | base_stall[s+1];
    base_flush = '0;
    for (int s = 0; s < NSTAGE - 1; s++)
      base_flush[s+1] = base_stall[s] && !base_stall[s+1];
  end

  always_comb begin
    stall       = base_stall;
    flush       = base_flush;
    inst_cancel = inst_data_ok && (state == DRAIN || take);
    if (take) begin
      for (int s = 0; s < COMMIT; s++) begin
        stall[s] = 1'b0;
        flush[s] = 1'b1;
      end
      flush[COMMIT] = !base_stall[COMMIT];
    end
    if (inst_cancel) flush[STG_ID] = 1'b1;
    if (rst) begin
      stall       = '0;
      flush       = '1;
      inst_cancel = 1'b0;
    end
  end

  // Drain FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cancel_cnt <= 4'd0;
    end else if (take) begin
      cancel_cnt <= drain_ld;
      state      <= (drain_ld != 4'd0) ? DRAIN : RUN;
    end else if (state == DRAIN && inst_data_ok) begin
      cancel_cnt <= cancel_cnt - 4'd1;
      if (cancel_cnt <= 4'd1) state <= RUN;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl_n.sv
module tb_pipe_ctrl_n;
  localparam int NSTAGE = 5;
  localparam int RW     = 5;

  typedef struct packed {
    logic [4:0] st;
    logic [4:0] fl;
    logic       ca;
    logic       iok;
    logic       dok;
    logic [2:0] io;
    logic [2:0] dout;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 inst_req, inst_addr_ok, inst_data_ok;
  logic                 data_req, data_addr_ok, data_data_ok;
  logic                 id_rs_ren, id_rt_ren;
  logic [RW-1:0]        id_rs, id_rt;
  logic [NSTAGE-1:0]    stg_wen, stg_late, ext_stall;
  logic [NSTAGE*RW-1:0] stg_wreg;
  logic                 exc, eret;
  logic [NSTAGE-1:0]    stall, flush;
  logic                 inst_cancel, inst_req_ok, data_req_ok;
  logic [2:0]           inst_outst, data_outst;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  pipe_ctrl_n #(.NSTAGE(5), .COMMIT(3), .MAX_OUTST(2), .RW(5)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .id_rs_ren(id_rs_ren), .id_rs(id_rs), .id_rt_ren(id_rt_ren), .id_rt(id_rt),
    .stg_wen(stg_wen), .stg_wreg(stg_wreg), .stg_late(stg_late),
    .ext_stall(ext_stall), .exc(exc), .eret(eret),
    .stall(stall), .flush(flush), .inst_cancel(inst_cancel),
    .inst_req_ok(inst_req_ok), .data_req_ok(data_req_ok),
    .inst_outst(inst_outst), .data_outst(data_outst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clr();
    inst_req = 0; inst_addr_ok = 0; inst_data_ok = 0;
    data_req = 0; data_addr_ok = 0; data_data_ok = 0;
    id_rs_ren = 0; id_rs = '0; id_rt_ren = 0; id_rt = '0;
    stg_wen = '0; stg_wreg = '0; stg_late = '0; ext_stall = '0;
    exc = 0; eret = 0;
  endtask

  // Inputs are already driven; queue the expectation, compare on the
  // falling edge, then move to just after the next rising edge.
  task automatic step(input string tag, input logic [4:0] st, input logic [4:0] fl,
                      input logic ca, input logic iok, input logic dok,
                      input logic [2:0] io, input logic [2:0] dout);
    exp_t e;
    q.push_back('{st: st, fl: fl, ca: ca, iok: iok, dok: dok, io: io, dout: dout});
    @(negedge clk);
    e = q.pop_front();
    chk({tag, ".stall"},       {3'b0, stall},       {3'b0, e.st});
    chk({tag, ".flush"},       {3'b0, flush},       {3'b0, e.fl});
    chk({tag, ".inst_cancel"}, {7'b0, inst_cancel}, {7'b0, e.ca});
    chk({tag, ".inst_req_ok"}, {7'b0, inst_req_ok}, {7'b0, e.iok});
    chk({tag, ".data_req_ok"}, {7'b0, data_req_ok}, {7'b0, e.dok});
    chk({tag, ".inst_outst"},  {5'b0, inst_outst},  {5'b0, e.io});
    chk({tag, ".data_outst"},  {5'b0, data_outst},  {5'b0, e.dout});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; clr();
    step("reset", 5'b00000, 5'b11111, 0, 1, 1, 3'd0, 3'd0);
    rst = 0;

    // late-result hazards
    clr(); stg_wen[2] = 1; stg_wreg[2*RW +: RW] = 5'd8; stg_late[2] = 1; id_rs_ren = 1; id_rs = 5'd8;
    step("load_use", 5'b00011, 5'b00100, 0, 1, 1, 3'd0, 3'd0);
    stg_late[2] = 0;
    step("load_use_done", 5'b00000, 5'b00000, 0, 1, 1, 3'd0, 3'd0);
    clr(); stg_wen[3] = 1; stg_wreg[3*RW +: RW] = 5'd0; stg_late[3] = 1; id_rs_ren = 1; id_rs = 5'd0;
    step("r0_no_haz", 5'b00000, 5'b00000, 0, 1, 1, 3'd0, 3'd0);
    clr(); stg_wen[4] = 1; stg_wreg[4*RW +: RW] = 5'd17; stg_late[4] = 1; id_rt_ren = 1; id_rt = 5'd17;
    step("rt_haz_wb", 5'b00011, 5'b00100, 0, 1, 1, 3'd0, 3'd0);

    // inst credits
    clr(); inst_req = 1; inst_addr_ok = 1;
    step("iacc1", 5'b00000, 5'b00000, 0, 1, 1, 3'd0, 3'd0);
    step("iacc2", 5'b00000, 5'b00000, 0, 1, 1, 3'd1, 3'd0);
    clr();
    step("ifull", 5'b00001, 5'b00010, 0, 0, 1, 3'd2, 3'd0);
    inst_data_ok = 1;
    step("iret", 5'b00001, 5'b00010, 0, 0, 1, 3'd2, 3'd0);
    clr();
    step("iafter_ret", 5'b00000, 5'b00000, 0, 1, 1, 3'd1, 3'd0);
    inst_req = 1; inst_addr_ok = 1;
    step("iacc3", 5'b00000, 5'b00000, 0, 1, 1, 3'd1, 3'd0);
    inst_data_ok = 1;
    step("iacc_ret_full", 5'b00001, 5'b00010, 0, 0, 1, 3'd2, 3'd0);
    clr();
    step("ihold2", 5'b00001, 5'b00010, 0, 0, 1, 3'd2, 3'd0);

    // exception drain with two stale returns
    exc = 1;
    step("exc_drain", 5'b00000, 5'b01111, 0, 0, 1, 3'd2, 3'd0);
    clr(); inst_data_ok = 1;
    step("stale1", 5'b00001, 5'b00010, 1, 0, 1, 3'd2, 3'd0);
    inst_req = 1; inst_addr_ok = 1;
    step("stale2", 5'b00000, 5'b00010, 1, 1, 1, 3'd1, 3'd0);
    clr(); inst_data_ok = 1;
    step("fresh_ret", 5'b00000, 5'b00000, 0, 1, 1, 3'd1, 3'd0);

    // exception while a stage beyond COMMIT stalls
    clr(); exc = 1; ext_stall[3] = 1;
    step("exc_stall3", 5'b01000, 5'b10111, 0, 1, 1, 3'd0, 3'd0);

    // data credits
    clr(); data_req = 1; data_addr_ok = 1;
    step("dacc1", 5'b00000, 5'b00000, 0, 1, 1, 3'd0, 3'd0);
    data_addr_ok = 0;
    step("dwait", 5'b00111, 5'b01000, 0, 1, 1, 3'd0, 3'd1);
    data_addr_ok = 1;
    step("dacc2", 5'b00000, 5'b00000, 0, 1, 1, 3'd0, 3'd1);
    clr();
    step("dfull", 5'b00111, 5'b01000, 0, 1, 0, 3'd0, 3'd2);
    data_data_ok = 1;
    step("dret1", 5'b00111, 5'b01000, 0, 1, 0, 3'd0, 3'd2);
    step("dret2", 5'b00000, 5'b00000, 0, 1, 1, 3'd0, 3'd1);
    clr();
    step("dempty", 5'b00000, 5'b00000, 0, 1, 1, 3'd0, 3'd0);

    // eret with the only outstanding return arriving the same cycle
    inst_req = 1; inst_addr_ok = 1;
    step("iacc_e", 5'b00000, 5'b00000, 0, 1, 1, 3'd0, 3'd0);
    clr(); eret = 1; inst_data_ok = 1;
    step("eret_sameret", 5'b00000, 5'b01111, 1, 1, 1, 3'd1, 3'd0);
    clr();
    step("eret_idle", 5'b00000, 5'b00000, 0, 1, 1, 3'd0, 3'd0);

    // reset in the middle of a drain
    inst_req = 1; inst_addr_ok = 1;
    step("iacc_r", 5'b00000, 5'b00000, 0, 1, 1, 3'd0, 3'd0);
    clr(); exc = 1;
    step("exc_r", 5'b00000, 5'b01111, 0, 1, 1, 3'd1, 3'd0);
    clr(); rst = 1;
    step("rst_drain", 5'b00000, 5'b11111, 0, 1, 1, 3'd1, 3'd0);
    rst = 0;
    step("post_rst", 5'b00000, 5'b00000, 0, 1, 1, 3'd0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
